// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FP32 field widths, rounding modes and converter states
package fpu_pkg;

  localparam int EXP_W    = 8;
  localparam int FRAC_W   = 23;
  localparam int BIAS     = 127;
  localparam int EXP_BASE = 158;
  localparam logic [31:0] POS_ZERO = 32'h0000_0000;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_t;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rmode_t legal_mode(input logic [2:0] m);
    return (m > 3'd4) ? RM_RNE : rmode_t'(m);
  endfunction

endpackage

// File: rtl/fp_round_unit.sv
// rtl/fp_round_unit.sv - combinational FP32 fraction rounding, shared with the adder
module fp_round_unit
  import fpu_pkg::*;
(
  input  logic              sign,
  input  logic [FRAC_W-1:0] frac,
  input  logic              g,
  input  logic              s,
  input  rmode_t            mode,
  output logic [FRAC_W-1:0] frac_rounded,
  output logic              carry,
  output logic              inexact
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    case (mode)
      RM_RNE:  inc = g & (s | frac[0]);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (g | s);
      RM_RUP:  inc = ~sign & (g | s);
      RM_RMM:  inc = g;
      default: inc = g & (s | frac[0]);
    endcase
  end

  // On carry the fraction wraps to zero and the caller bumps the exponent.
  assign {carry, frac_rounded} = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};
  assign inexact = g | s;

endmodule

// File: rtl/int_to_fp_converter.sv
// rtl/int_to_fp_converter.sv - iterative 32-bit integer to FP32 converter with handshakes
module int_to_fp_converter
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] int_in,
  input  logic        is_signed,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] fp_result,
  output logic        inexact,
  output logic        invalid_rm
);

  state_t            state;
  logic              sign;
  logic [31:0]       mag;
  logic [EXP_W-1:0]  exp;
  rmode_t            mode;

  logic              in_sign;
  logic [31:0]       in_mag;
  logic [FRAC_W-1:0] frac_rounded;
  logic              carry;
  logic              rnd_inexact;

  assign in_sign = is_signed & int_in[31];
  assign in_mag  = in_sign ? (~int_in + 32'd1) : int_in;

  fp_round_unit u_round (
    .sign         (sign),
    .frac         (mag[30:8]),
    .g            (mag[7]),
    .s            (|mag[6:0]),
    .mode         (mode),
    .frac_rounded (frac_rounded),
    .carry        (carry),
    .inexact      (rnd_inexact)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      fp_result  <= POS_ZERO;
      inexact    <= 1'b0;
      invalid_rm <= 1'b0;
      sign       <= 1'b0;
      mag        <= 32'd0;
      exp        <= '0;
      mode       <= RM_RNE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign       <= in_sign;
            mag        <= in_mag;
            exp        <= EXP_W'(EXP_BASE);
            mode       <= legal_mode(r_mode);
            invalid_rm <= (r_mode > 3'd4);
            in_ready   <= 1'b0;
            // Zero skips normalisation and is packed as +0 in ROUND.
            state      <= (in_mag == 32'd0) ? ROUND : NORM;
          end
        end
        NORM: begin
          if (mag[31]) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            exp <= exp - EXP_W'(1);
          end
        end
        ROUND: begin
          if (mag[31]) begin
            fp_result <= {sign, exp + {{(EXP_W-1){1'b0}}, carry}, frac_rounded};
            inexact   <= rnd_inexact;
          end else begin
            fp_result <= POS_ZERO;
            inexact   <= 1'b0;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/int_to_fp_converter.md
Name: int_to_fp_converter

Overview:
- Multi-cycle converter from a 32-bit integer (signed or unsigned) to an IEEE-754 single-precision word.
- It is the encode/pack counterpart of the adder's unpack front end, and produces FP32 operands for the adder.
- Uses the same rounding-mode encoding as the adder.
- Normalises iteratively, one bit per cycle, then rounds and packs.
- Sits behind a valid/ready handshake on each side.

Parameters:
- EXP_BASE, 158, biased exponent of an unshifted 32-bit magnitude (127+31).
- BIAS, 127, FP32 exponent bias.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  int_in, is_signed and r_mode are valid.
- in_ready  out  1  converter can accept an operand.
- int_in  in  32  integer operand.
- is_signed  in  1  1 = two's complement, 0 = unsigned.
- r_mode  in  3  000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 reserved.
- out_valid  out  1  fp_result and flags are valid.
- out_ready  in  1  consumer takes the result.
- fp_result  out  32  {sign, exponent[7:0], fraction[22:0]}.
- inexact  out  1  guard or sticky bit was nonzero.
- invalid_rm  out  1  r_mode was reserved; the result was rounded as RNE.

Behaviour:
- Reset values: in_ready=1, out_valid=0, fp_result=0, inexact=0, invalid_rm=0, state=IDLE. Reset can occur in any state, including mid-NORM or DONE; any in-flight operand is discarded and nothing is emitted.
- State machine: IDLE, NORM, ROUND, DONE.
- in_ready = (state==IDLE). Only IDLE accepts operands.
- IDLE: on in_valid&in_ready, capture:
  - sign = is_signed & int_in[31].
  - mag = sign ? (~int_in+1) : int_in, 32-bit unsigned. 0x80000000 signed gives mag 0x80000000.
  - exp = EXP_BASE.
  - r_mode is latched; reserved values set invalid_rm and are replaced by RNE.
  - If mag==0: fp_result=0x00000000 (+0, never -0), inexact=0, next state DONE. Otherwise next state NORM.
- NORM: if mag[31]==0, mag<<=1 and exp-=1, stay in NORM. If mag[31]==1, go to ROUND. At most 31 shift cycles.
- ROUND:
  - frac = mag[30:8], g = mag[7], s = |mag[6:0], lsb = mag[8].
  - Increment condition per mode:
    - RNE: g&(s|lsb).
    - RTZ: 0.
    - RDN: sign&(g|s).
    - RUP: !sign&(g|s).
    - RMM: g.
  - Rounded fraction is 24-bit {0,frac}+inc. On carry out, frac=0 and exp+=1.
  - Register fp_result={sign,exp,frac}, inexact=g|s; next state DONE.
  - Overflow is impossible (max exp 159); no subnormals are produced.
- DONE: out_valid=1. fp_result and flags are held stable while out_ready=0. On out_ready=1, go to IDLE and deassert out_valid on the next edge.
- Latency, from the accept edge to the first edge at which out_valid is high:
  - L+2 cycles, where L = leading zeros of mag.
  - 1 cycle for zero input.
  - Range 2..33.
- Throughput: no overlap. The next operand is accepted the cycle after the DONE handshake.
- Inputs arriving while in_ready=0 are ignored; the upstream must hold in_valid.

Decomposition:
- Shared package fpu_pkg:
  - rounding-mode enum (RNE/RTZ/RDN/RUP/RMM), shared with the adder;
  - state enum;
  - FP32 field widths, BIAS, EXP_BASE, positive-zero constant.
- Sub-module fp_round_unit: purely combinational. Inputs sign, frac[22:0], g, s, mode; outputs frac_rounded[22:0], carry, inexact. It is reusable by the adder's rounding stage.
- The top module holds the FSM, mag/exp registers and handshake.

Test Plan:
- int_in=1, unsigned, RNE -> fp_result=0x3F800000, inexact=0, out_valid exactly 33 cycles after accept.
- int_in=0xFFFFFFFF, signed, RNE (-1) -> 0xBF800000. Same operand unsigned: RNE -> 0x4F800000 with inexact=1; RTZ -> 0x4F7FFFFF with inexact=1.
- int_in=0x80000000, signed -> 0xCF000000, latency 2. int_in=0 -> 0x00000000, latency 1, inexact=0.
- int_in=0x01000001 unsigned (tie): RNE -> 0x4B800000; RMM and RUP -> 0x4B800001; RDN -> 0x4B800000. Signed 0xFEFFFFFF (-16777217) with RDN -> 0xCB800001. r_mode=111 -> RNE result with invalid_rm=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and fp_result stable, in_ready=0. On release, in_ready=1 the next cycle and back-to-back operands convert correctly.
- Assert rst_n low mid-NORM (e.g. cycle 5 of int_in=1) -> immediately out_valid=0, in_ready=1, no stale result after release.
